// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

  // Encoding 2'd3 is never entered; the FSM decodes it back to StIdle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Borrow when y exceeds x, or when x == y and a borrow comes in.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock behind a start/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             cell_d, cell_bout;
  logic             show;

  full_subtractor u_cell (
    .x    (a_sh_q[0]),
    .y    (b_sh_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state logic for the FSM and the serial datapath.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StShift;
          a_sh_d   = a;
          b_sh_d   = b;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          cnt_d    = '0;
          res_d    = '0;
          borrow_d = 1'b0;
        end
      end
      StShift: begin
        a_sh_d           = a_sh_q >> 1;
        b_sh_d           = b_sh_q >> 1;
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = cell_d;
        borrow_d         = cell_bout;
        cnt_d            = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
    end
  end

  // Results are masked while bits are in flight so partial sums never leak out.
  always_comb begin
    busy       = (state_q == StShift);
    done       = (state_q == StDone);
    show       = ~busy;
    diff       = show ? res_q : '0;
    borrow_out = show & borrow_q;
    overflow   = show & (a_msb_q ^ b_msb_q) & (res_q[WIDTH-1] ^ a_msb_q);
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances against a timeline model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic       busy8, done8, bo8, ov8;
  logic [7:0] diff8;
  logic       busy1, done1, bo1, ov1;
  logic [0:0] diff1;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .a(a[0:0]), .b(b[0:0]),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1), .overflow(ov1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Plain-arithmetic reference for a w-bit subtraction.
  task automatic ref_sub(input int w, input logic [7:0] av, input logic [7:0] bv,
                         output logic [7:0] d, output logic bo, output logic ov);
    int m, ua, ub, sa, sb, sd;
    m  = 1 << w;
    ua = int'(av) % m;
    ub = int'(bv) % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    sd = sa - sb;
    d  = 8'((ua - ub + m) % m);
    bo = (ua < ub);
    ov = (sd < -(m / 2)) || (sd > m / 2 - 1);
  endtask

  // Model: per instance, time since accept decides busy/done/result visibility.
  int         wv[2] = '{8, 1};
  bit         active[2] = '{0, 0};
  int         t[2] = '{0, 0};
  int         accepts[2] = '{0, 0};
  logic [7:0] pend_d[2], exp_d[2] = '{8'h0, 8'h0};
  logic       pend_bo[2], pend_ov[2], exp_bo[2] = '{0, 0}, exp_ov[2] = '{0, 0};

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        active[i] = 0;
        exp_d[i]  = '0;
        exp_bo[i] = 0;
        exp_ov[i] = 0;
      end else if (active[i]) begin
        t[i]++;
        if (t[i] == wv[i]) begin
          exp_d[i]  = pend_d[i];
          exp_bo[i] = pend_bo[i];
          exp_ov[i] = pend_ov[i];
        end else if (t[i] == wv[i] + 1) begin
          active[i] = 0;
        end
      end else if (start) begin
        active[i] = 1;
        t[i]      = 0;
        accepts[i]++;
        ref_sub(wv[i], a, b, pend_d[i], pend_bo[i], pend_ov[i]);
        exp_d[i]  = '0;
        exp_bo[i] = 0;
        exp_ov[i] = 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic eb, ed;
    for (int i = 0; i < 2; i++) begin
      eb = active[i] && (t[i] < wv[i]);
      ed = active[i] && (t[i] == wv[i]);
      if (i == 0) begin
        chk("busy8", 32'(busy8), 32'(eb));
        chk("done8", 32'(done8), 32'(ed));
        if (!eb) begin
          chk("diff8", 32'(diff8), 32'(exp_d[0]));
          chk("borrow8", 32'(bo8), 32'(exp_bo[0]));
          chk("ovf8", 32'(ov8), 32'(exp_ov[0]));
        end
      end else begin
        chk("busy1", 32'(busy1), 32'(eb));
        chk("done1", 32'(done1), 32'(ed));
        if (!eb) begin
          chk("diff1", 32'(diff1), 32'(exp_d[1]));
          chk("borrow1", 32'(bo1), 32'(exp_bo[1]));
          chk("ovf1", 32'(ov1), 32'(exp_ov[1]));
        end
      end
    end
  end

  // One-shot operation on the 8-bit instance with literal expectations.
  task automatic op8(input string name, input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic ebo, input logic eov);
    int k, n;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = cyc;
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 32'(cyc - k), 32'd8);
    chk({name, "_diff"}, 32'(diff8), 32'(ed));
    chk({name, "_borrow"}, 32'(bo8), 32'(ebo));
    chk({name, "_ovf"}, 32'(ov8), 32'(eov));
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] md;
    logic       mbo, mov;
    int         k, ndone, guard;

    // Pin the model itself with hand-computed values.
    ref_sub(8, 8'h3C, 8'h15, md, mbo, mov);
    chk("model_3c_15", {23'd0, mov, mbo, md}, {23'd0, 1'b0, 1'b0, 8'h27});
    ref_sub(8, 8'h80, 8'h01, md, mbo, mov);
    chk("model_80_01", {23'd0, mov, mbo, md}, {23'd0, 1'b1, 1'b0, 8'h7F});
    ref_sub(1, 8'h00, 8'h01, md, mbo, mov);
    chk("model_w1_0_1", {23'd0, mov, mbo, md}, {23'd0, 1'b1, 1'b1, 8'h01});

    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy8), 32'd0);
    chk("reset_diff", 32'(diff8), 32'd0);
    rst = 1'b0;

    op8("t1", 8'h3C, 8'h15, 8'h27, 1'b0, 1'b0);
    op8("t2", 8'h15, 8'h3C, 8'hD9, 1'b1, 1'b0);
    op8("t3", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

    // Hold start and scramble operands: one done, next accept at k+10.
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    @(negedge clk);
    k = cyc;
    ndone = 0;
    for (int j = 1; j <= 10; j++) begin
      a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      if (done8) begin
        ndone++;
        chk("hold_diff", 32'(diff8), 32'hE1);
        chk("hold_done_edge", 32'(cyc - k), 32'd8);
      end
      if (j == 9) chk("hold_idle_k9", 32'(busy8), 32'd0);
      if (j == 10) chk("hold_accept_k10", 32'(busy8), 32'd1);
    end
    chk("hold_single_done", 32'(ndone), 32'd1);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Reset during the 4th SHIFT cycle.
    a = 8'h3C; b = 8'h15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outputs", {27'd0, busy8, done8, bo8, ov8, |diff8}, 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("rst_no_done", 32'(ndone), 32'd0);
    op8("t5", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

    // Random traffic: start held often, operands change every cycle, rare resets.
    accepts[0] = 0;
    accepts[1] = 0;
    guard = 0;
    while ((accepts[0] < 1000 || accepts[1] < 1000) && guard < 30000) begin
      @(negedge clk);
      a     = 8'($urandom);
      b     = 8'($urandom);
      start = ($urandom_range(3) != 0);
      rst   = ($urandom_range(299) == 0);
      guard++;
    end
    start = 1'b0;
    rst   = 1'b0;
    chk("rand_ops_w8", 32'(accepts[0] >= 1000), 32'd1);
    chk("rand_ops_w1", 32'(accepts[1] >= 1000), 32'd1);
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
